data_ram_bus: RTL
=================

// Module: data_ram_bus
// PURPOSE
//  Bus-slave data memory for the core's MEM stage. Word-addressed synchronous RAM with byte
//  enables, cs/as request strobe, rdy completion handshake and programmable wait states.
//  Sits behind the bus decoder; the MEM stage stalls until rdy. Out-of-range accesses flag err.
// PARAMETERS
//  DATA_W      32    data word width in bits; multiple of 8
//  ADDR_W      12    word-address width
//  DEPTH       4096  implemented words (<= 2**ADDR_W); addr >= DEPTH is out of range
//  WAIT_CYCLES 0     extra wait states inserted before each access (0..15)
// PORTS
//  clk      in   1         clock; all state updates on rising edge
//  rst      in   1         reset, asynchronous, active-high
//  cs       in   1         chip select from bus decoder
//  as       in   1         address strobe; request = cs & as
//  rw       in   1         1 = write, 0 = read
//  addr     in   ADDR_W    word address
//  wr_data  in   DATA_W    write data
//  be       in   DATA_W/8  byte enables, bit i -> wr_data[8i+7:8i]
//  rd_data  out  DATA_W    read data, valid while rdy=1 on a read
//  rdy      out  1         one-cycle completion pulse
//  err      out  1         out-of-range flag, valid only with rdy
// BEHAVIOUR
//  Reset: one clock; rst is asynchronous, active-high. rst=1 forces state IDLE, rdy=0, err=0,
//   rd_data=0, wait counter=0. Memory array contents are not reset.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if cs&as sampled 1: capture rw/addr/wr_data/be, cnt<=WAIT_CYCLES, go BUSY.
//   BUSY: cnt!=0: cnt<=cnt-1, stay. cnt==0: perform access at this edge, go RESP.
//   RESP: rdy=1 (err per capture) for exactly this cycle; go IDLE unconditionally.
//  Latency: request sampled in cycle 0 -> rdy high in cycle WAIT_CYCLES+2, one cycle wide.
//  Access (at BUSY exit edge, using captured values only):
//   write, in range: byte i of mem[addr] <= wr_data byte i where be[i]=1; others kept.
//   write, be==0: no array change; rdy still issued.
//   read, in range: rd_data <= mem[addr] (whole word; be ignored on reads).
//   out of range (addr >= DEPTH): no array change, rd_data <= 0, err=1 with rdy.
//   write: rd_data holds its previous value.
//  rd_data holds until the next completed read; rdy and err are 0 outside RESP.
//  cs/as/inputs are ignored in BUSY and RESP; the master holds the request until rdy
//   and must drop as in the rdy cycle or a new request is taken the cycle after (IDLE).
//  Back-to-back: as held through rdy -> a second access is accepted in the following
//   IDLE cycle; throughput one access per WAIT_CYCLES+3 cycles.
//  Read after write to the same address returns the new data (write completes first).
//  Reset mid-operation: rst in BUSY before exit edge -> write not performed, no rdy issued.
//  Captured inputs are registered: changes to addr/wr_data after acceptance have no effect.
// TESTING
//  1 Reset: assert rst mid-cycle -> rdy=0, err=0, rd_data=0 immediately, FSM IDLE.
//  2 WAIT_CYCLES=2: write addr=5 data=32'hDEADBEEF be=4'hF, then read addr=5 ->
//    each rdy exactly 4 cycles after request, read rd_data=32'hDEADBEEF, err=0.
//  3 Byte enables: mem[7]=32'h11223344, write 32'hAABBCCDD be=4'b0101 -> read 32'h11BB33DD.
//  4 DEPTH=3000: read addr=3000 -> rdy with err=1, rd_data=0; write addr=4095 -> err=1,
//    subsequent read addr=4095 still err=1; addr=2999 access -> err=0.
//  5 Hold as through rdy with addr changing after acceptance -> second access starts the
//    cycle after rdy, uses new addr; first access used originally captured addr.
//  6 rst pulse while BUSY on write to addr=9 (old 32'h0) -> no rdy; later read addr=9 = 32'h0.

Source files
------------

// File: rtl/data_ram_bus_if.sv
// Bus between the MEM-stage address decoder and a data-memory slave.
// Latency: none (wires only).
// Backpressure: request held by master (cs & as) until the slave pulses rdy.
//
// Signals:
//   cs, as   chip select / address strobe; a request is cs & as
//   rw       1 = write, 0 = read
//   addr     word address
//   wr_data  write data
//   be       byte enables, bit i covers wr_data[8i+7:8i]
//   rd_data  read data, meaningful while rdy is high on a read
//   rdy      one-cycle completion pulse
//   err      out-of-range flag, meaningful only with rdy
interface data_ram_bus_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  cs;
    logic                  as;
    logic                  rw;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rd_data;
    logic                  rdy;
    logic                  err;

    modport master (
        output cs, as, rw, addr, wr_data, be,
        input  rd_data, rdy, err
    );

    modport slave (
        input  cs, as, rw, addr, wr_data, be,
        output rd_data, rdy, err
    );
endinterface

// File: rtl/data_ram_bus.sv
// Word-addressed data RAM with byte enables behind a cs/as/rdy bus handshake.
// Latency: request sampled in cycle 0 -> rdy in cycle WAIT_CYCLES+2; one access per WAIT_CYCLES+3 cycles.
// Backpressure: master holds the request until rdy; bus inputs are ignored while busy or responding.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset (array contents are not cleared)
//   bus     data_ram_bus_if slave modport (cs/as/rw/addr/wr_data/be in, rd_data/rdy/err out)
module data_ram_bus #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    data_ram_bus_if.slave  bus
);

    localparam int BE_W = DATA_W / 8;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Everything the access needs, latched at acceptance so the master may
    // change the bus afterwards without affecting this transaction.
    typedef struct packed {
        logic              rw;
        logic              oor;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
        logic [BE_W-1:0]   be;
    } req_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    req_t              req_q,   req_d;
    logic [DATA_W-1:0] rd_data_q;

    logic              access;
    logic              mem_we;
    logic              rd_en;

    logic [DATA_W-1:0] mem [DEPTH];

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        access  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cs && bus.as) begin
                    req_d.rw      = bus.rw;
                    req_d.oor     = ({1'b0, bus.addr} >= DEPTH_L);
                    req_d.addr    = bus.addr;
                    req_d.wr_data = bus.wr_data;
                    req_d.be      = bus.be;
                    cnt_d         = WAIT_INIT;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access happens on the edge that leaves BUSY.
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The rst_i term keeps a write from landing if reset arrives coincident
    // with the exit edge; the FSM register alone already covers earlier resets.
    assign mem_we = access && req_q.rw && !req_q.oor && !rst_i;
    assign rd_en  = access && !req_q.rw;

    //------------------------------------------------------------------
    // Control and read-data registers
    //------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            // Out-of-range reads return zero; writes leave rd_data untouched.
            if (rd_en) begin
                rd_data_q <= req_q.oor ? '0 : mem[req_q.addr];
            end
        end
    end

    //------------------------------------------------------------------
    // Storage array: no reset, byte-granular writes
    //------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_q.be[i]) begin
                    mem[req_q.addr][8*i +: 8] <= req_q.wr_data[8*i +: 8];
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign bus.rdy     = (state_q == RESP);
    assign bus.err     = (state_q == RESP) && req_q.oor;
    assign bus.rd_data = rd_data_q;

endmodule
